// File: rtl/frame_max_finder.sv
// Streaming frame-maximum stage driving an external 8-bit comparator; reports max and its index.
// Optional index tracking is enabled with `define FRAME_MAX_FINDER_INDEX_EN.
module frame_max_finder #(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] cmp_a,
    output logic [7:0] cmp_b,
    input  logic [7:0] cmp_max,
    input  logic       cmp_gt,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_max,
    output logic [7:0] out_idx,
    input  logic       out_ready
);

    localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFirst, StRun, StDone} state_e;

    state_e     state;
    logic [7:0] max_r;
    logic [7:0] cnt_r;
    logic       in_ready_r;
    logic       busy_r;
    logic       out_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            max_r       <= 8'd0;
            cnt_r       <= 8'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StFirst;
                        cnt_r      <= 8'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                StFirst: begin
                    if (in_valid) begin
                        max_r <= in_data;
                        cnt_r <= 8'd1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        max_r <= cmp_max;
                        // Hold the counter on the last sample so it never exceeds FRAME_LEN-1.
                        if (cnt_r == LastCnt) begin
                            state       <= StDone;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state       <= StIdle;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef FRAME_MAX_FINDER_INDEX_EN
    logic [7:0] idx_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 8'd0;
        end else if (in_valid && state == StFirst) begin
            idx_r <= 8'd0;
        end else if (in_valid && state == StRun && cmp_gt) begin
            idx_r <= cnt_r;
        end
    end

    assign out_idx = idx_r;
`else
    logic unused_cmp_gt;
    assign unused_cmp_gt = cmp_gt;
    assign out_idx       = 8'd0;
`endif

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_max   = max_r;
    assign cmp_a     = in_data;
    assign cmp_b     = max_r;

endmodule

// File: tb/tb_frame_max_finder.sv
// Self-checking bench for frame_max_finder: vector table, hand-written corner sequences, random frames.
module tb_frame_max_finder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;
    logic [7:0] cmp_max;
    logic       cmp_gt;
    logic       busy;
    logic       out_valid;
    logic [7:0] out_max;
    logic [7:0] out_idx;
    logic       out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_max_finder #(.FRAME_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_max   (cmp_max),
        .cmp_gt    (cmp_gt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    // Combinational comparator: returns in2 on equality.
    always_comb begin
        cmp_gt  = cmp_a > cmp_b;
        cmp_max = (cmp_a > cmp_b) ? cmp_a : cmp_b;
    end

    typedef struct {
        logic [0:7][7:0] s;
        logic [7:0]      mx;
        logic [7:0]      idx;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_idx(input logic [7:0] i);
`ifdef FRAME_MAX_FINDER_INDEX_EN
        return i;
`else
        return 8'd0 & i;
`endif
    endfunction

    // Reference model: maximum and first position of it, scanned over the whole frame.
    task automatic ref_model(input logic [0:7][7:0] s, output logic [7:0] mx, output logic [7:0] ix);
        mx = s[0];
        ix = 8'd0;
        for (int i = 1; i < 8; i++) begin
            if (s[i] > mx) begin
                mx = s[i];
                ix = 8'(i);
            end
        end
    endtask

    task automatic start_frame(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " ready_after_start"}, 32'(in_ready), 32'd1);
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [0:7][7:0] s, input int first, input int last, input int gap,
                        input string tag);
        logic [7:0] run;
        run = s[0];
        for (int i = 1; i < first; i++) run = (s[i] > run) ? s[i] : run;
        for (int i = first; i <= last; i++) begin
            if (i > first) begin
                repeat (gap) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = s[i];
            chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            if (i > 0) chk({tag, " cmp_b"}, 32'(cmp_b), 32'(run));
            if (i == 7) chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
            run = (i == 0) ? s[0] : ((s[i] > run) ? s[i] : run);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input logic [7:0] mx, input logic [7:0] ix, input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_max"}, 32'(out_max), 32'(mx));
        chk({tag, " out_idx"}, 32'(out_idx), 32'(exp_idx(ix)));
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid_cleared"}, 32'(out_valid), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic full_frame(input logic [0:7][7:0] s, input int gap, input logic [7:0] mx,
                              input logic [7:0] ix, input string tag);
        start_frame(tag);
        send(s, 0, 7, gap, tag);
        check_result(mx, ix, tag);
        take_result(tag);
    endtask

    initial begin
        logic [0:7][7:0] s;
        logic [7:0]      mx;
        logic [7:0]      ix;
        logic [7:0]      held_max;
        logic [7:0]      held_idx;

        tbl[0].s = {8'd3, 8'd9, 8'd1, 8'd9, 8'd200, 8'd7, 8'd200, 8'd5};
        tbl[0].mx = 8'd200; tbl[0].idx = 8'd4;
        tbl[1].s = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[1].mx = 8'd0; tbl[1].idx = 8'd0;
        tbl[2].s = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[2].mx = 8'd255; tbl[2].idx = 8'd0;
        tbl[3].s = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        tbl[3].mx = 8'd8; tbl[3].idx = 8'd7;

        // Reset values
        in_data = 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_max", 32'(out_max), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst cmp_b", 32'(cmp_b), 32'd0);
        chk("rst cmp_a", 32'(cmp_a), 32'h5A);
        rst_n = 1'b1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle ignore busy", 32'(busy), 32'd0);

        for (int v = 0; v < 4; v++) full_frame(tbl[v].s, 0, tbl[v].mx, tbl[v].idx, $sformatf("vec%0d", v));

        // Stall gaps give the same result
        full_frame(tbl[0].s, 3, tbl[0].mx, tbl[0].idx, "gap3");

        // Backpressure: outputs hold, start ignored
        start_frame("bp");
        send(tbl[0].s, 0, 7, 0, "bp");
        held_max = out_max;
        held_idx = out_idx;
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_result(tbl[0].mx, tbl[0].idx, "bp hold");
            chk("bp stable_max", 32'(out_max), 32'(held_max));
            chk("bp stable_idx", 32'(out_idx), 32'(held_idx));
        end
        start = 1'b0;
        take_result("bp");
        @(negedge clk);
        chk("bp start_ignored", 32'(in_ready), 32'd0);

        // Reset after the 4th accept
        start_frame("rstmid");
        send(tbl[0].s, 0, 3, 0, "rstmid");
        rst_n = 1'b0;
        #1;
        chk("rstmid in_ready", 32'(in_ready), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid out_valid", 32'(out_valid), 32'd0);
        chk("rstmid out_max", 32'(out_max), 32'd0);
        chk("rstmid out_idx", 32'(out_idx), 32'd0);
        chk("rstmid cmp_b", 32'(cmp_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        full_frame(s, 0, 8'd80, 8'd7, "after_rst");

        // Random frames against the reference model; narrow ranges provoke ties
        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < 8; i++)
                s[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            ref_model(s, mx, ix);
            full_frame(s, int'($urandom_range(0, 2)), mx, ix, $sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
